// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with a shadow/active digit buffer committed at frame wrap.
// seg/dp/an are registered one cycle behind the scan state; frame_start lines up with those outputs.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 0,
  parameter int LZ_BLANK    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [HW-1:0]         shadow_hex_q, shadow_hex_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [HW-1:0]         active_hex_q, active_hex_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic                  pending_q, pending_d;
  logic                  wrap_q, wrap_d;
  logic                  frame_start_q, frame_start_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick, commit, an_on, nib_dp, zrun;
  logic [3:0]            nib;
  logic [6:0]            lit;
  logic [NUM_DIGITS-1:0] sel, blank;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h7E;
      4'h1: hex2seg = 7'h30;
      4'h2: hex2seg = 7'h6D;
      4'h3: hex2seg = 7'h79;
      4'h4: hex2seg = 7'h33;
      4'h5: hex2seg = 7'h5B;
      4'h6: hex2seg = 7'h5F;
      4'h7: hex2seg = 7'h70;
      4'h8: hex2seg = 7'h7F;
      4'h9: hex2seg = 7'h73;
      4'hA: hex2seg = 7'h77;
      4'hB: hex2seg = 7'h1F;
      4'hC: hex2seg = 7'h4E;
      4'hD: hex2seg = 7'h3D;
      4'hE: hex2seg = 7'h4F;
      default: hex2seg = 7'h47;
    endcase
  endfunction

  always_comb begin : scan_next
    tick   = en && (cnt_q == CNT_LAST);
    wrap_d = tick && (idx_q == IDX_LAST);
    commit = wrap_d && pending_q;

    cnt_d = cnt_q;
    if (en) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // Commit reads the pre-edge shadow, so a coincident load lands for the next frame.
    shadow_hex_d  = load ? hex_in : shadow_hex_q;
    shadow_dp_d   = load ? dp_in : shadow_dp_q;
    active_hex_d  = commit ? shadow_hex_q : active_hex_q;
    active_dp_d   = commit ? shadow_dp_q : active_dp_q;
    pending_d     = load | (pending_q & ~commit);
    frame_start_d = wrap_q;
  end

  always_comb begin : drive_next
    sel    = '0;
    blank  = '0;
    nib    = 4'h0;
    nib_dp = 1'b0;
    zrun   = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sel[k] = (idx_q == IW'(k));
      if (sel[k]) begin
        nib    = active_hex_q[4*k +: 4];
        nib_dp = active_dp_q[k];
      end
    end
    // Leading-zero run from the top digit down; digit 0 is never part of it.
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zrun     = zrun && (active_hex_q[4*k +: 4] == 4'h0);
      blank[k] = zrun && (LZ_BLANK != 0);
    end

    an_on = en && (cnt_q != '0);
    lit   = (|(sel & blank)) ? 7'h00 : hex2seg(nib);
    an_d  = (an_on ? sel : '0) ^ {NUM_DIGITS{INV}};
    seg_d = (an_on ? lit : 7'h00) ^ {7{INV}};
    dp_d  = (an_on & nib_dp) ^ INV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_hex_q  <= '0;
      shadow_dp_q   <= '0;
      active_hex_q  <= '0;
      active_dp_q   <= '0;
      pending_q     <= 1'b0;
      wrap_q        <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= {7{INV}};
      dp_q          <= INV;
      an_q          <= {NUM_DIGITS{INV}};
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_hex_q  <= shadow_hex_d;
      shadow_dp_q   <= shadow_dp_d;
      active_hex_q  <= active_hex_d;
      active_dp_q   <= active_dp_d;
      pending_q     <= pending_d;
      wrap_q        <= wrap_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign pending     = pending_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter: REFRESH_DIV, default 1000, clock cycles per digit slot (legal >= 2).
REQ-003 Parameter: ACTIVE_LOW, default 0, when 1 the block SHALL invert seg, dp and an at the output register.
REQ-004 Parameter: LZ_BLANK, default 0, when 1 the block SHALL enable leading-zero blanking.
REQ-005 Port: clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Port: rst  in  1  synchronous, active-high reset.
REQ-007 Port: en  in  1  scan enable; 0 freezes scan and blanks the display.
REQ-008 Port: load  in  1  single-cycle strobe capturing hex_in/dp_in into the shadow buffer.
REQ-009 Port: hex_in  in  4*NUM_DIGITS  nibble k = digit k value; digit 0 is least significant.
REQ-010 Port: dp_in  in  NUM_DIGITS  bit k = decimal point of digit k.
REQ-011 Port: seg  out  7  {a,b,c,d,e,f,g}, a = bit 6; 1 = lit when ACTIVE_LOW=0.
REQ-012 Port: dp  out  1  decimal point of the driven digit.
REQ-013 Port: an  out  NUM_DIGITS  one-hot digit enable; bit k drives digit k.
REQ-014 Port: pending  out  1  shadow holds data not yet committed to the display.
REQ-015 Port: frame_start  out  1  one-cycle pulse marking the start of each scan frame.

Function
REQ-016 Decode (hex -> seg) SHALL be: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=73 A=77 b=1F C=4E d=3D E=4F F=47; digit 9 SHALL omit segment d.
REQ-017 Prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0 while en=1, and SHALL hold while en=0.
REQ-018 tick SHALL be en=1 AND cnt=REFRESH_DIV-1; on tick, digit index idx SHALL advance mod NUM_DIGITS.
REQ-019 On load, shadow SHALL take {hex_in, dp_in} and pending SHALL be set to 1.
REQ-020 On tick with idx=NUM_DIGITS-1 and pending=1 (pre-edge values), active SHALL take the pre-edge shadow and pending SHALL clear.
REQ-021 If load coincides with such a commit, active SHALL take the old shadow, shadow SHALL take the new data, and pending SHALL remain 1.
REQ-022 seg, dp and an SHALL be registered, computed from the pre-edge idx, cnt and active: one cycle of latency.
REQ-023 an SHALL be onehot(idx) when en=1 and cnt!=0; otherwise all off (anti-ghost dead cycle at each slot start).
REQ-024 seg/dp SHALL be the decode of active digit idx while an is on; otherwise all off.
REQ-025 With LZ_BLANK=1, digit k>0 SHALL show seg all off when active nibbles k..NUM_DIGITS-1 are all zero; its dp SHALL still show; digit 0 SHALL never be blanked.
REQ-026 frame_start SHALL assert for exactly one cycle, the cycle after a tick with idx=NUM_DIGITS-1.
REQ-027 With NUM_DIGITS=1, idx SHALL stay 0 and every tick SHALL be a frame boundary.

Reset
REQ-028 Reset SHALL set cnt=0, idx=0, shadow=0, active=0, pending=0, frame_start=0, seg/dp/an inactive (all 0 when ACTIVE_LOW=0, all 1 when ACTIVE_LOW=1).
REQ-029 Reset SHALL take priority over load and tick in the same cycle; reset mid-frame SHALL discard pending data.

Verification (NUM_DIGITS=4, REFRESH_DIV=4 unless stated)
REQ-030 Bench SHALL cover: NUM_DIGITS=1, load each of 0..F, en=1 -> seg matches REQ-016 table, including 9=73 and b=1F.
REQ-031 Bench SHALL cover: rst released, en=1 from cycle 0 -> an=0 at cycles 1 and 5; an=0001 at cycles 2-4; an=0010 at cycles 6-8; frame_start high at cycle 17 only.
REQ-032 Bench SHALL cover: load hex_in=0x1234 mid-frame -> pending=1 and display unchanged until the frame wrap; then pending=0, digit 3 shows 30 and digit 0 shows 33.
REQ-033 Bench SHALL cover: load coincident with the commit tick -> display shows the prior shadow and pending stays 1; the next frame shows the new data.
REQ-034 Bench SHALL cover: LZ_BLANK=1, hex_in=0x0050, dp_in=4'b1000 -> digits 3 and 2 have seg=00, digit 3 has dp=1, digit 1 shows 5B, digit 0 shows 7E.
REQ-035 Bench SHALL cover: ACTIVE_LOW=1 with en dropped mid-slot -> seg=7F, dp=1 and an=F the next cycle, and cnt/idx hold; after en returns, scanning resumes from the held slot.
